// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and golden model for the 5-bit ALU stimulus
//               driver/checker. Holds the opcode and FSM state encodings,
//               the LFSR feedback taps, and the reference ALU function.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcode encodings as seen on the ALU KEY inputs.
    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Feedback taps for x^10 + x^7 + 1 on a left-shifting register:
    // the new bit 0 is q[9] ^ q[6].
    localparam logic [9:0] LFSR_TAPS = 10'b10_0100_0000;

    // Result reported by the ALU for a division by zero.
    localparam logic [9:0] DIV0_RESULT = 10'h3FF;

    // Saturation ceiling of the mismatch counter.
    localparam logic [9:0] ERR_MAX = 10'h3FF;

    // Opcode schedule: the two LSBs of the vector index rotate through
    // ADD, SUB, MUL, DIV so every op is exercised every four vectors.
    function automatic op_t op_for_idx(input logic [1:0] idx);
        op_t op;
        case (idx)
            2'd0:    op = OP_ADD;
            2'd1:    op = OP_SUB;
            2'd2:    op = OP_MUL;
            default: op = OP_DIV;
        endcase
        return op;
    endfunction

    // Reference ALU: all results are 10-bit unsigned.
    function automatic logic [9:0] alu_golden(
        input logic [4:0] a,
        input logic [4:0] b,
        input op_t        op
    );
        logic [9:0] r;
        logic [4:0] q;
        q = 5'd0;
        case (op)
            OP_ADD: r = {5'd0, a} + {5'd0, b};
            OP_SUB: r = {5'd0, a} - {5'd0, b};   // wraps mod 1024
            OP_MUL: r = {5'd0, a} * {5'd0, b};
            default: begin
                if (b == 5'd0) begin
                    r = DIV0_RESULT;
                end else begin
                    q = a / b;
                    r = {5'd0, q};
                end
            end
        endcase
        return r;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_stim_checker_lfsr10.sv
`default_nettype none
// ============================================================================
// Module      : lfsr10
// Description : 10-bit Fibonacci LFSR (x^10 + x^7 + 1) producing the operand
//               pairs for the ALU stimulus driver.
// Ports       : clk     - system clock
//               rst     - asynchronous reset, active-high (loads RESET_VAL)
//               en_i    - advance the register by one step
//               load_i  - load seed_i (has priority over en_i)
//               seed_i  - value loaded when load_i is high
//               q_o     - current LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr10
    import alu_pkg::*;
#(
    parameter logic [9:0] RESET_VAL = 10'h001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       load_i,
    input  logic [9:0] seed_i,
    output logic [9:0] q_o
);

    logic [9:0] lfsr_q;
    logic [9:0] lfsr_d;
    logic       feedback;

    assign feedback = ^(lfsr_q & LFSR_TAPS);

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = seed_i;
        end else if (en_i) begin
            lfsr_d = {lfsr_q[8:0], feedback};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= RESET_VAL;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q_o = lfsr_q;

endmodule : lfsr10
`default_nettype wire

// File: rtl/alu_stim_checker.sv
`default_nettype none
// ============================================================================
// Module      : alu_stim_checker
// Description : On-chip stimulus driver and checker for the 5-bit ALU.
//               Drives LFSR-generated operands and a rotating opcode onto the
//               ALU switch/key inputs, waits LAT cycles, samples the LED
//               result and compares it with the golden model.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               start           - pulse, begins a run from IDLE or DONE
//               stop            - level, aborts to IDLE (wins over start)
//               alu_sw/alu_key  - operand bus {A,B} and opcode to the ALU
//               alu_ledr        - ALU result
//               busy/done/pass  - run status
//               err_count       - saturating mismatch count
//               fail_idx/got    - index and result of the first mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module alu_stim_checker
    import alu_pkg::*;
#(
    parameter int unsigned NUM_VEC = 16,
    parameter int unsigned LAT     = 2,
    parameter logic [9:0]  SEED    = 10'b00001_00010
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    output logic [9:0] alu_sw,
    output logic [1:0] alu_key,
    input  logic [9:0] alu_ledr,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [9:0] err_count,
    output logic [9:0] fail_idx,
    output logic [9:0] fail_got
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [9:0] SEED_EFF  = (SEED == 10'd0) ? 10'h001 : SEED;
    localparam logic [9:0] LAST_IDX  = 10'(NUM_VEC - 1);
    // WAIT lasts LAT cycles: the counter is loaded with LAT-1 and CHECK is
    // entered on the cycle it reads zero.
    localparam logic [3:0] WAIT_INIT = 4'(LAT - 1);

    state_t     state_q;
    logic [9:0] alu_sw_q;
    logic [1:0] alu_key_q;
    logic [9:0] exp_q;
    logic [3:0] wait_q;
    logic [9:0] vec_idx_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [9:0] err_count_q;
    logic [9:0] fail_idx_q;
    logic [9:0] fail_got_q;

    logic [9:0] lfsr_val;
    logic       lfsr_load;
    logic       lfsr_en;
    logic       run_start;
    logic       last_vec;
    logic       mismatch;
    op_t        op_cur;

    assign run_start = start && !stop &&
                       ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_vec  = (vec_idx_q == LAST_IDX);
    assign mismatch  = (alu_ledr != exp_q);
    assign op_cur    = op_for_idx(vec_idx_q[1:0]);

    // The LFSR reloads on every run start and steps once per checked vector
    // that is not the last, so vector i always uses SEED stepped i times.
    assign lfsr_load = run_start;
    assign lfsr_en   = !stop && (state_q == ST_CHECK) && !last_vec;

    lfsr10 #(
        .RESET_VAL (SEED_EFF)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .en_i   (lfsr_en),
        .load_i (lfsr_load),
        .seed_i (SEED_EFF),
        .q_o    (lfsr_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_sw_q    <= 10'd0;
            alu_key_q   <= 2'b00;
            exp_q       <= 10'd0;
            wait_q      <= 4'd0;
            vec_idx_q   <= 10'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= 10'd0;
            fail_idx_q  <= 10'd0;
            fail_got_q  <= 10'd0;
        end else if (stop) begin
            // Abort: park the ALU inputs at zero but keep the error records
            // so the cause of the abort can still be inspected.
            state_q   <= ST_IDLE;
            alu_sw_q  <= 10'd0;
            alu_key_q <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_DRIVE;
                        vec_idx_q   <= 10'd0;
                        err_count_q <= 10'd0;
                        fail_idx_q  <= 10'd0;
                        fail_got_q  <= 10'd0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                    end
                end

                ST_DRIVE: begin
                    // ALU inputs only ever change on this edge.
                    alu_sw_q  <= lfsr_val;
                    alu_key_q <= op_cur;
                    exp_q     <= alu_golden(lfsr_val[9:5], lfsr_val[4:0], op_cur);
                    wait_q    <= WAIT_INIT;
                    state_q   <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (wait_q == 4'd0) begin
                        state_q <= ST_CHECK;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end

                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_count_q != ERR_MAX) begin
                            err_count_q <= err_count_q + 10'd1;
                        end
                        if (err_count_q == 10'd0) begin
                            fail_idx_q <= vec_idx_q;
                            fail_got_q <= alu_ledr;
                        end
                    end
                    if (last_vec) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        // Final verdict includes this cycle's comparison.
                        pass_q  <= (err_count_q == 10'd0) && !mismatch;
                    end else begin
                        vec_idx_q <= vec_idx_q + 10'd1;
                        state_q   <= ST_DRIVE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign alu_sw    = alu_sw_q;
    assign alu_key   = alu_key_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign fail_idx  = fail_idx_q;
    assign fail_got  = fail_got_q;

endmodule : alu_stim_checker
`default_nettype wire
